// File: rtl/geofence_pkg.sv
// Shared geofence types: coordinate width, point and cross-product result types.
// Used by the cross-product arbiter, the vertex-sort engine and the inside-test engine.
package geofence_pkg;

  localparam int COORD_W = 10;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } point_t;

  typedef logic signed [2*COORD_W+2:0] xprod_t;

endpackage

// File: rtl/cross_product_pipe.sv
// Two-stage pipelined cross product (p1-ref) x (p2-ref) with valid/id sideband.
// Stage 1 registers the two partial products; stage 2 registers their difference.
module cross_product_pipe #(
  parameter int COORD_W = 10,
  parameter int ID_W    = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_valid,
  input  logic [ID_W-1:0]           i_id,
  input  logic [COORD_W-1:0]        i_ref_x,
  input  logic [COORD_W-1:0]        i_ref_y,
  input  logic [COORD_W-1:0]        i_p1_x,
  input  logic [COORD_W-1:0]        i_p1_y,
  input  logic [COORD_W-1:0]        i_p2_x,
  input  logic [COORD_W-1:0]        i_p2_y,
  output logic                      o_valid,
  output logic [ID_W-1:0]           o_id,
  output logic signed [2*COORD_W+2:0] o_value,
  output logic                      o_nonneg,
  output logic                      o_busy
);

  localparam int DW = COORD_W + 1;
  localparam int PW = 2*COORD_W + 2;
  localparam int RW = 2*COORD_W + 3;

  logic signed [DW-1:0] w_dx1, w_dy1, w_dx2, w_dy2;
  logic signed [PW-1:0] w_a, w_b;
  logic signed [RW-1:0] w_diff;

  logic                 r_s1_valid;
  logic [ID_W-1:0]      r_s1_id;
  logic signed [PW-1:0] r_a, r_b;
  logic                 r_s2_valid;
  logic [ID_W-1:0]      r_s2_id;
  logic signed [RW-1:0] r_value;
  logic                 r_nonneg;

  assign w_dx1 = $signed({1'b0, i_p1_x}) - $signed({1'b0, i_ref_x});
  assign w_dy1 = $signed({1'b0, i_p1_y}) - $signed({1'b0, i_ref_y});
  assign w_dx2 = $signed({1'b0, i_p2_x}) - $signed({1'b0, i_ref_x});
  assign w_dy2 = $signed({1'b0, i_p2_y}) - $signed({1'b0, i_ref_y});

  // Operands are sign-extended to the full product width so the multiply is exact.
  assign w_a    = PW'(w_dx1) * PW'(w_dy2);
  assign w_b    = PW'(w_dx2) * PW'(w_dy1);
  assign w_diff = RW'(r_a) - RW'(r_b);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; the datapath registers are reset too because their idle value
  // is visible on the response ports.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_id    <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_s2_valid <= 1'b0;
      r_s2_id    <= '0;
      r_value    <= '0;
      r_nonneg   <= 1'b0;
    end else begin
      r_s1_valid <= i_valid;
      r_s1_id    <= i_id;
      r_a        <= w_a;
      r_b        <= w_b;
      r_s2_valid <= r_s1_valid;
      r_s2_id    <= r_s1_id;
      r_value    <= w_diff;
      r_nonneg   <= ~w_diff[RW-1];
    end
  end

  assign o_valid  = r_s2_valid;
  assign o_id     = r_s2_id;
  assign o_value  = r_value;
  assign o_nonneg = r_nonneg;
  assign o_busy   = r_s1_valid | r_s2_valid;

endmodule

// File: rtl/cross_product_arbiter.sv
// Round-robin arbiter sharing one cross_product_pipe among NUM_REQ requesters.
// Optional feature macro XPA_LOCK_EN adds the lock port for held ownership.
module cross_product_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int COORD_W = geofence_pkg::COORD_W,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*COORD_W-1:0]   ref_x,
  input  logic [NUM_REQ*COORD_W-1:0]   ref_y,
  input  logic [NUM_REQ*COORD_W-1:0]   p1_x,
  input  logic [NUM_REQ*COORD_W-1:0]   p1_y,
  input  logic [NUM_REQ*COORD_W-1:0]   p2_x,
  input  logic [NUM_REQ*COORD_W-1:0]   p2_y,
`ifdef XPA_LOCK_EN
  input  logic [NUM_REQ-1:0]           lock,
`endif
  output logic [NUM_REQ-1:0]           gnt,
  output logic                         rsp_valid,
  output logic [ID_W-1:0]              rsp_id,
  output logic signed [2*COORD_W+2:0]  rsp_value,
  output logic                         rsp_nonneg,
  output logic                         busy
);

  logic [ID_W-1:0]    r_ptr;
  logic [NUM_REQ-1:0] w_gnt;
  logic               w_gnt_any;
  logic [ID_W-1:0]    w_gnt_idx;
  logic [ID_W-1:0]    w_ptr_nxt;
  logic               w_hold;
  logic [ID_W-1:0]    w_hold_id;

  function automatic logic [ID_W-1:0] rr_idx(input logic [ID_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_REQ) s -= NUM_REQ;
    return ID_W'(s);
  endfunction

`ifdef XPA_LOCK_EN
  logic            r_own_vld;
  logic [ID_W-1:0] r_own_id;

  // Ownership is only honoured for the requester granted at the previous edge.
  assign w_hold    = r_own_vld && req[r_own_id] && lock[r_own_id];
  assign w_hold_id = r_own_id;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_own_vld <= 1'b0;
      r_own_id  <= '0;
    end else begin
      r_own_vld <= w_gnt_any && lock[w_gnt_idx];
      if (w_gnt_any) r_own_id <= w_gnt_idx;
    end
  end
`else
  assign w_hold    = 1'b0;
  assign w_hold_id = '0;
`endif

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    w_gnt     = '0;
    if (!reset) begin
      if (w_hold) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = w_hold_id;
      end else begin
        // Scan downward so the request closest to r_ptr is the last to win.
        for (int k = NUM_REQ-1; k >= 0; k--) begin
          if (req[rr_idx(r_ptr, k)]) begin
            w_gnt_any = 1'b1;
            w_gnt_idx = rr_idx(r_ptr, k);
          end
        end
      end
      if (w_gnt_any) w_gnt[w_gnt_idx] = 1'b1;
    end
  end

  assign gnt       = w_gnt;
  assign w_ptr_nxt = (int'(w_gnt_idx) == NUM_REQ-1) ? '0 : ID_W'(w_gnt_idx + 1'b1);

  // While ownership is held the owner is re-granted, so r_ptr keeps owner+1.
  always_ff @(posedge clk) begin
    if (reset)          r_ptr <= '0;
    else if (w_gnt_any) r_ptr <= w_ptr_nxt;
  end

  cross_product_pipe #(
    .COORD_W (COORD_W),
    .ID_W    (ID_W)
  ) u_pipe (
    .clk      (clk),
    .reset    (reset),
    .i_valid  (w_gnt_any),
    .i_id     (w_gnt_idx),
    .i_ref_x  (ref_x[int'(w_gnt_idx)*COORD_W +: COORD_W]),
    .i_ref_y  (ref_y[int'(w_gnt_idx)*COORD_W +: COORD_W]),
    .i_p1_x   (p1_x[int'(w_gnt_idx)*COORD_W +: COORD_W]),
    .i_p1_y   (p1_y[int'(w_gnt_idx)*COORD_W +: COORD_W]),
    .i_p2_x   (p2_x[int'(w_gnt_idx)*COORD_W +: COORD_W]),
    .i_p2_y   (p2_y[int'(w_gnt_idx)*COORD_W +: COORD_W]),
    .o_valid  (rsp_valid),
    .o_id     (rsp_id),
    .o_value  (rsp_value),
    .o_nonneg (rsp_nonneg),
    .o_busy   (busy)
  );

endmodule

// File: tb/tb_cross_product_arbiter.sv
// Self-checking bench for cross_product_arbiter: directed cases plus randomized
// traffic against a queue-based reference model (lock cases when XPA_LOCK_EN is set).
module tb_cross_product_arbiter;
  import geofence_pkg::*;

  localparam int N   = 2;
  localparam int W   = COORD_W;
  localparam int IDW = 1;
  localparam int RW  = 2*W + 3;
`ifdef XPA_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic [N-1:0]         req = '0;
  logic [N-1:0]         lock = '0;
  logic [N*W-1:0]       ref_x, ref_y, p1_x, p1_y, p2_x, p2_y;
  logic [N-1:0]         gnt;
  logic                 rsp_valid;
  logic [IDW-1:0]       rsp_id;
  logic signed [RW-1:0] rsp_value;
  logic                 rsp_nonneg;
  logic                 busy;

  point_t op_ref[N], op_p1[N], op_p2[N];

  typedef struct {
    int     due;
    int     id;
    longint val;
  } exp_t;

  exp_t  q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    edge_n   = 0;
  int    m_ptr    = 0;
  bit    m_own_v  = 1'b0;
  int    m_own_id = 0;
  string phase    = "reset";

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      ref_x[i*W +: W] = op_ref[i].x;
      ref_y[i*W +: W] = op_ref[i].y;
      p1_x[i*W +: W]  = op_p1[i].x;
      p1_y[i*W +: W]  = op_p1[i].y;
      p2_x[i*W +: W]  = op_p2[i].x;
      p2_y[i*W +: W]  = op_p2[i].y;
    end
  end

  cross_product_arbiter #(
    .NUM_REQ (N),
    .COORD_W (W),
    .ID_W    (IDW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .ref_x      (ref_x),
    .ref_y      (ref_y),
    .p1_x       (p1_x),
    .p1_y       (p1_y),
    .p2_x       (p2_x),
    .p2_y       (p2_y),
`ifdef XPA_LOCK_EN
    .lock       (lock),
`endif
    .gnt        (gnt),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_value  (rsp_value),
    .rsp_nonneg (rsp_nonneg),
    .busy       (busy)
  );

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %0d expected %0d", phase, tag, got, exp);
    end
  endtask

  // Cross product straight from the geometric definition.
  function automatic longint xprod(input int i);
    longint dx1, dy1, dx2, dy2;
    dx1 = longint'(op_p1[i].x) - longint'(op_ref[i].x);
    dy1 = longint'(op_p1[i].y) - longint'(op_ref[i].y);
    dx2 = longint'(op_p2[i].x) - longint'(op_ref[i].x);
    dy2 = longint'(op_p2[i].y) - longint'(op_ref[i].y);
    return dx1*dy2 - dx2*dy1;
  endfunction

  function automatic int model_pick();
    if (reset) return -1;
    if (LOCK_EN && m_own_v && req[m_own_id] && lock[m_own_id]) return m_own_id;
    for (int k = 0; k < N; k++)
      if (req[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  task automatic set_op(input int i, input int rx, input int ry, input int ax, input int ay,
                        input int bx, input int by);
    op_ref[i].x = W'(rx); op_ref[i].y = W'(ry);
    op_p1[i].x  = W'(ax); op_p1[i].y  = W'(ay);
    op_p2[i].x  = W'(bx); op_p2[i].y  = W'(by);
  endtask

  // One clock: check gnt before the edge, advance the model, check responses after.
  task automatic step();
    int           pick;
    logic [N-1:0] exp_gnt;
    bit           rst_now;
    bit           ev;
    longint       v;
    bit           lk;
    exp_t         e;
    #1;
    pick    = model_pick();
    exp_gnt = '0;
    v       = 0;
    lk      = 1'b0;
    if (pick >= 0) begin
      exp_gnt[pick] = 1'b1;
      v  = xprod(pick);
      lk = LOCK_EN && lock[pick];
    end
    check("gnt", longint'(gnt), longint'(exp_gnt));
    rst_now = reset;
    @(posedge clk);
    edge_n++;
    if (rst_now) begin
      q.delete();
      m_ptr = 0; m_own_v = 1'b0; m_own_id = 0;
    end else if (pick >= 0) begin
      q.push_back('{edge_n + 1, pick, v});
      m_ptr = (pick + 1) % N; m_own_v = lk; m_own_id = pick;
    end else begin
      m_own_v = 1'b0;
    end
    #1;
    if (rst_now) begin
      check("rst_valid",  longint'(rsp_valid),  0);
      check("rst_busy",   longint'(busy),       0);
      check("rst_id",     longint'(rsp_id),     0);
      check("rst_value",  longint'(rsp_value),  0);
      check("rst_nonneg", longint'(rsp_nonneg), 0);
    end else begin
      ev = (q.size() > 0) && (q[0].due == edge_n);
      if (ev) e = q.pop_front();
      check("rsp_valid", longint'(rsp_valid), longint'(ev));
      if (ev) begin
        check("rsp_id",     longint'(rsp_id),            longint'(e.id));
        check("rsp_value",  longint'($signed(rsp_value)), e.val);
        check("rsp_nonneg", longint'(rsp_nonneg),        longint'(e.val >= 0));
      end
      check("busy", longint'(busy), longint'(ev || q.size() > 0));
    end
  endtask

  task automatic idle(input int n);
    req = '0; lock = '0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    for (int i = 0; i < N; i++) set_op(i, 0, 0, 0, 0, 0, 0);

    phase = "reset"; reset = 1'b1; req = '1;
    for (int i = 0; i < 3; i++) step();
    reset = 1'b0;
    idle(2);

    phase = "positive";
    set_op(0, 0, 0, 10, 0, 0, 10);
    req = 2'b01; step();
    idle(3);

    phase = "full_neg";
    set_op(1, 0, 0, 0, 1023, 1023, 0);
    req = 2'b10; step();
    idle(3);

    phase = "round_robin";
    set_op(0, 3, 4, 100, 7, 9, 200);
    set_op(1, 500, 500, 10, 900, 1000, 2);
    req = 2'b11;
    for (int i = 0; i < 6; i++) step();
    idle(3);

    phase = "reset_mid";
    req = 2'b01; step();
    req = '0; reset = 1'b1; step();
    reset = 1'b0; idle(2);
    req = 2'b11; step();
    idle(3);

    phase = "collinear";
    set_op(0, 5, 5, 7, 7, 9, 9);
    req = 2'b01; step();
    idle(3);

    if (LOCK_EN) begin
      phase = "lock";
      reset = 1'b1; idle(1); reset = 1'b0;
      req = 2'b11; lock = 2'b01;
      for (int i = 0; i < 4; i++) step();
      lock = 2'b00; step();
      idle(3);
    end

    phase = "random";
    for (int c = 0; c < 400; c++) begin
      reset = ($urandom_range(0, 39) == 0);
      req   = N'($urandom);
      lock  = ($urandom_range(0, 2) != 0) ? N'($urandom) : '0;
      for (int i = 0; i < N; i++)
        set_op(i, int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
               int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
               int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
      step();
    end
    reset = 1'b0;
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
